seq_serializer: RTL



---
 rtl/seq_serializer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/seq_serializer.sv
// seq_serializer: parallel words -> serial bit stream on x for the 1011 detector; first bit 1 cycle after accept.
// bit_en=0 freezes the shifter and drops din_ready; `define SER_PARITY_EN appends an even-parity bit per word.
module seq_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             bit_en,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
  // a one-bit word carries no parity bit
  localparam bit PAR_EN = (WIDTH > 1);
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
  localparam bit PAR_EN = 1'b0;
`endif

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic             x_n, x_valid_n, frame_start_n, frame_end_n;
  logic             load_point;
  logic [WIDTH-1:0] din_ord, sh_ord;
  logic             cur_bit;

  // Re-index a word so that bit 0 is the first bit on the wire.
  function automatic logic [WIDTH-1:0] to_wire_order(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = MSB_FIRST ? w[WIDTH-1-i] : w[i];
    end
    return r;
  endfunction

  always_comb begin
    din_ord = to_wire_order(din);
    sh_ord  = to_wire_order(shreg);
    cur_bit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (cnt == CW'(i)) cur_bit = sh_ord[i];
    end
  end

  always_comb begin
    load_point = (state == IDLE) || ((state == SHIFT) && (cnt == CNT_FULL) && !PAR_EN);
`ifdef SER_PARITY_EN
    if (state == PAR) load_point = 1'b1;
`endif
  end

  assign din_ready = bit_en & load_point;
  assign busy      = (state != IDLE);

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    shreg_n       = shreg;
    x_n           = x;
    x_valid_n     = 1'b0;
    frame_start_n = 1'b0;
    frame_end_n   = 1'b0;
    if (bit_en) begin
      if (load_point) begin
        if (din_valid) begin
          shreg_n       = din;
          x_n           = din_ord[0];
          x_valid_n     = 1'b1;
          frame_start_n = 1'b1;
          frame_end_n   = (WIDTH == 1) && !PAR_EN;
          cnt_n         = CW'(1);
          state_n       = SHIFT;
        end else begin
          x_n     = 1'b0;
          cnt_n   = '0;
          state_n = IDLE;
        end
      end else if (cnt != CNT_FULL) begin
        x_n         = cur_bit;
        x_valid_n   = 1'b1;
        frame_end_n = (cnt == CNT_LAST) && !PAR_EN;
        cnt_n       = cnt + CW'(1);
      end
`ifdef SER_PARITY_EN
      else begin
        // XOR of the data bits makes the frame's count of ones even
        x_n         = ^shreg;
        x_valid_n   = 1'b1;
        frame_end_n = 1'b1;
        state_n     = PAR;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      shreg       <= '0;
      x           <= 1'b0;
      x_valid     <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      shreg       <= shreg_n;
      x           <= x_n;
      x_valid     <= x_valid_n;
      frame_start <= frame_start_n;
      frame_end   <= frame_end_n;
    end
  end

endmodule
